// File: rtl/input_debounce_pkg.sv
// Shared constants and helpers for the input_debounce block.
// Optional interrupt status is enabled with the INPUT_DEBOUNCE_IRQ_EN macro.
package input_debounce_pkg;

  localparam int unsigned DEF_NUM_IN        = 8;
  localparam int unsigned DEF_STABLE_CYCLES = 50000;

  // Per-channel view of the debouncer: output level agrees with sync2 or not.
  typedef enum logic {
    CH_STABLE   = 1'b0,
    CH_SETTLING = 1'b1
  } chan_state_e;

  // Counter must hold values 0 .. stable_cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    int unsigned w;
    if (stable_cycles <= 1) begin
      w = 1;
    end else begin
      w = unsigned'($clog2(stable_cycles + 1));
    end
    return w;
  endfunction

endpackage

// File: rtl/input_debounce_chan.sv
// One input channel: 2-flop synchronizer, stability counter, debounced level
// and registered one-cycle rise/fall pulses.
module debounce_chan
  import input_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic RAW_IN,
  output logic CLEAN_OUT,
  output logic RISE_PULSE,
  output logic FALL_PULSE
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] TERM_CNT = CW'(STABLE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          clean_q, clean_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  chan_state_e   state_c;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= RAW_IN;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  // State is implied by whether the synchronized input disagrees with the output.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    state_c = (sync2_q == clean_q) ? CH_STABLE : CH_SETTLING;
    unique case (state_c)
      CH_STABLE: begin
        cnt_d = '0;
      end
      CH_SETTLING: begin
        if (cnt_q == TERM_CNT) begin
          clean_d = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign CLEAN_OUT  = clean_q;
  assign RISE_PULSE = rise_q;
  assign FALL_PULSE = fall_q;

endmodule

// File: rtl/input_debounce.sv
// Board input conditioner: NUM_IN independent debounce channels, plus sticky
// maskable edge-interrupt status when INPUT_DEBOUNCE_IRQ_EN is defined.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int unsigned NUM_IN        = DEF_NUM_IN,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [NUM_IN-1:0] RAW_IN,
  output logic [NUM_IN-1:0] CLEAN_OUT,
  output logic [NUM_IN-1:0] RISE_PULSE,
  output logic [NUM_IN-1:0] FALL_PULSE
`ifdef INPUT_DEBOUNCE_IRQ_EN
  ,
  input  logic [NUM_IN-1:0] IRQ_MASK,
  input  logic [NUM_IN-1:0] IRQ_CLR,
  output logic [NUM_IN-1:0] IRQ_STATUS,
  output logic              IRQ
`endif
);

  for (genvar g = 0; g < int'(NUM_IN); g++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .RAW_IN    (RAW_IN[g]),
      .CLEAN_OUT (CLEAN_OUT[g]),
      .RISE_PULSE(RISE_PULSE[g]),
      .FALL_PULSE(FALL_PULSE[g])
    );
  end

`ifdef INPUT_DEBOUNCE_IRQ_EN
  logic [NUM_IN-1:0] status_q, status_d;
  logic              irq_q, irq_d;

  // A new masked edge beats a simultaneous clear so no event is lost.
  always_comb begin
    status_d = (status_q & ~IRQ_CLR) | ((RISE_PULSE | FALL_PULSE) & IRQ_MASK);
    irq_d    = |status_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign IRQ_STATUS = status_q;
  assign IRQ        = irq_q;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: two instances (STABLE_CYCLES=4 and 1) checked
// against a sliding-window model, plus directed literal checks.
module tb_input_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw = 8'h00;
  logic [7:0] clean4, rise4, fall4;
  logic [7:0] clean1, rise1, fall1;
`ifdef INPUT_DEBOUNCE_IRQ_EN
  logic [7:0] mask = 8'h00;
  logic [7:0] clr  = 8'h00;
  logic [7:0] st4, st1;
  logic       irq4, irq1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  input_debounce #(.NUM_IN(8), .STABLE_CYCLES(4)) u_dut4 (
    .HCLK(clk), .HRESET(rst), .RAW_IN(raw),
    .CLEAN_OUT(clean4), .RISE_PULSE(rise4), .FALL_PULSE(fall4)
`ifdef INPUT_DEBOUNCE_IRQ_EN
    , .IRQ_MASK(mask), .IRQ_CLR(clr), .IRQ_STATUS(st4), .IRQ(irq4)
`endif
  );

  input_debounce #(.NUM_IN(8), .STABLE_CYCLES(1)) u_dut1 (
    .HCLK(clk), .HRESET(rst), .RAW_IN(raw),
    .CLEAN_OUT(clean1), .RISE_PULSE(rise1), .FALL_PULSE(fall1)
`ifdef INPUT_DEBOUNCE_IRQ_EN
    , .IRQ_MASK(mask), .IRQ_CLR(clr), .IRQ_STATUS(st1), .IRQ(irq1)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: hist[0] is RAW_IN sampled at this edge, so hist[2] is what the
  // second synchronizer flop presents at this edge. A channel flips once its
  // last S synchronized samples all disagree with the current output.
  logic [7:0] hist[$];
  logic [7:0] cm[2];
  logic [7:0] rm[2];
  logic [7:0] fm[2];
`ifdef INPUT_DEBOUNCE_IRQ_EN
  logic [7:0] sm[2];
  logic       im[2];
`endif
  bit mvalid = 1'b0;

  function automatic logic [7:0] flips(input int s, input logic [7:0] c);
    logic [7:0] f;
    f = 8'hFF;
    for (int k = 2; k <= s + 1; k++) f &= hist[k] ^ c;
    return f;
  endfunction

  always @(posedge clk) begin
    mvalid = 1'b1;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < 6; k++) hist.push_back(8'h00);
      for (int d = 0; d < 2; d++) begin
        cm[d] = 8'h00; rm[d] = 8'h00; fm[d] = 8'h00;
`ifdef INPUT_DEBOUNCE_IRQ_EN
        sm[d] = 8'h00; im[d] = 1'b0;
`endif
      end
    end else begin
`ifdef INPUT_DEBOUNCE_IRQ_EN
      for (int d = 0; d < 2; d++) begin
        im[d] = |sm[d];
        sm[d] = ((rm[d] | fm[d]) & mask) | (sm[d] & ~clr);
      end
`endif
      hist.push_front(raw);
      void'(hist.pop_back());
      for (int d = 0; d < 2; d++) begin
        logic [7:0] f;
        f = flips((d == 0) ? 4 : 1, cm[d]);
        rm[d] = f & ~cm[d];
        fm[d] = f & cm[d];
        cm[d] = cm[d] ^ f;
      end
    end
  end

  // Every cycle: both instances against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      check("m4_clean", 32'(clean4), 32'(cm[0]));
      check("m4_rise",  32'(rise4),  32'(rm[0]));
      check("m4_fall",  32'(fall4),  32'(fm[0]));
      check("m1_clean", 32'(clean1), 32'(cm[1]));
      check("m1_rise",  32'(rise1),  32'(rm[1]));
      check("m1_fall",  32'(fall1),  32'(fm[1]));
`ifdef INPUT_DEBOUNCE_IRQ_EN
      check("m4_status", 32'(st4), 32'(sm[0]));
      check("m4_irq",    32'(irq4), 32'(im[0]));
      check("m1_status", 32'(st1), 32'(sm[1]));
      check("m1_irq",    32'(irq1), 32'(im[1]));
`endif
    end
  end

  initial begin
    int nr;
    int at_i;
    rst = 1'b1;
    raw = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_clean4", 32'(clean4), 32'h0);
    check("reset_rise4",  32'(rise4),  32'h0);
    check("reset_fall4",  32'(fall4),  32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean rise on channel 0: S=4 after edge k+5, S=1 after edge k+2.
    raw[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 2) check("t1_s1_pre", 32'(clean1), 32'h00);
      if (i == 3) check("t1_s1_rise", 32'(rise1), 32'h01);
      if (i == 5) check("t1_pre", 32'(clean4), 32'h00);
      if (i == 6) begin
        check("t1_rise", 32'(rise4), 32'h01);
        check("t1_clean", 32'(clean4), 32'h01);
      end
      if (i == 7) check("t1_pulse_len", 32'(rise4), 32'h00);
    end

    // Three-cycle glitch on channel 1 must be swallowed by S=4.
    nr = 0;
    raw[1] = 1'b1;
    repeat (3) @(negedge clk);
    raw[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rise4[1] || fall4[1]) nr++;
    end
    check("glitch_pulses", 32'(nr), 32'h0);
    check("glitch_clean", 32'(clean4), 32'h01);

    // Bounce on channel 2, final toggle at i=8; rise expected at i=13.
    nr = 0;
    at_i = -1;
    for (int i = 0; i < 30; i++) begin
      if (i < 10 && (i % 2) == 0) raw[2] = ~raw[2];
      @(negedge clk);
      if (rise4[2]) begin
        nr++;
        at_i = i;
      end
    end
    check("bounce_rises", 32'(nr), 32'h1);
    check("bounce_when", 32'(at_i), 32'd13);

    // All channels together.
    raw = 8'h00;
    repeat (10) @(negedge clk);
    check("simul_idle", 32'(clean4), 32'h00);
    raw = 8'hFF;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) check("simul_rise_pre", 32'(rise4), 32'h00);
      if (i == 6) check("simul_rise", 32'(rise4), 32'hFF);
    end
    repeat (4) @(negedge clk);
    raw = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) check("simul_fall", 32'(fall4), 32'hFF);
    end
    repeat (6) @(negedge clk);

    // Reset while channel 4 counter sits at 2; rise must take full latency.
    raw[4] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_clean4", 32'(clean4), 32'h00);
    check("rst_mid_clean1", 32'(clean1), 32'h00);
    check("rst_mid_pulses", 32'(rise4 | fall4 | rise1 | fall1), 32'h00);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 5) check("rst_mid_pre", 32'(clean4), 32'h00);
      if (i == 6) check("rst_mid_rise", 32'(rise4), 32'h10);
    end

    // Randomized phase: sparse per-bit flips, occasional quiet stretches and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(2, 8)) @(negedge clk);
      end
      raw = raw ^ 8'($urandom & $urandom & $urandom);
      rst = ($urandom_range(0, 599) == 0);
`ifdef INPUT_DEBOUNCE_IRQ_EN
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      clr = 8'($urandom & $urandom & $urandom);
`endif
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
